xbus_mem_ctrl: RTL and testbench
================================

# xbus_mem_ctrl

Bus-side slave controller behind the core's xbus load/store formatting stage. It takes the already byte-lane-aligned request (`xbus_be`, `xbus_addr`, `xbus_wdata`) and decodes it to a synchronous single-port data SRAM or to a small MMIO register file (64-bit `mtime`, `tohost`). It returns the raw 32-bit `xbus_rdata` word and stalls the pipeline while a multi-cycle access is in flight.

## Interface
Parameters:
- `RAM_BASE`, 32'h0000_0000: RAM region base; region size is 4·2^RAM_AW bytes.
- `RAM_AW`, 12: SRAM word-address width.
- `MMIO_BASE`, 32'h1000_0000: MMIO region base; region size is 16 bytes.
- `WAIT_CYCLES`, 0: extra SRAM wait states; legal range 0..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `xbus_req`  in  1: load/store present; held stable by the core while `xbus_stall`=1.
- `xbus_we`  in  1: 1 = store.
- `xbus_be`  in  4: byte enables.
- `xbus_addr`  in  32: byte address.
- `xbus_wdata`  in  32: lane-aligned store data.
- `xbus_rdata`  out  32: raw read word; valid in the DONE cycle only.
- `xbus_stall`  out  1: freeze pipeline.
- `xbus_err`  out  1: one-cycle pulse in DONE for an unmapped access or `be`=0.
- `sram_ce`, `sram_we`  out  1 each: SRAM strobe and write enable.
- `sram_be`  out  4: SRAM byte enables.
- `sram_addr`  out  RAM_AW: word address.
- `sram_wdata`  out  32: SRAM write data.
- `sram_rdata`  in  32: SRAM read data, valid the cycle after `sram_ce`.
- `tohost`  out  32: host-communication register.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:**
  - `xbus_stall` = `xbus_req`, combinationally.
  - On a clock edge with `xbus_req`=1: capture we/be/addr/wdata into request registers and decode.
  - RAM hit goes to ACCESS with `cnt`=0.
  - MMIO hit or error goes straight to DONE.
- **ACCESS:**
  - `xbus_stall`=1.
  - At `cnt`=0: `sram_ce`=1, `sram_we`=req_we, and `sram_be`/`sram_addr`=addr[RAM_AW+1:2]/`sram_wdata` come from the captured registers.
  - At `cnt`=1: `rdata_q` <= `sram_rdata` for loads, or 0 for stores.
  - `cnt` increments every cycle. At `cnt`=WAIT_CYCLES+1, go to DONE.
  - SRAM outputs are 0 whenever `sram_ce`=0.
- **DONE:**
  - `xbus_stall`=0, `xbus_rdata`=`rdata_q`, `xbus_err`=`err_q`.
  - Unconditionally return to IDLE. `xbus_req` is ignored in this cycle, because the core retires at this edge.
- **MMIO map** (offset from MMIO_BASE):
  - 0x0 MTIME_LO, read-only.
  - 0x4 MTIME_HI, read-only.
  - 0x8 TOHOST, read/write; each byte is written when its `be` bit is set.
  - 0xC reads 0, writes are ignored, and no error is raised.
  - For MMIO reads, `rdata_q` loads at the IDLE capture edge.
- **mtime:** 64-bit counter, +1 every cycle, wraps from 2^64−1 to 0.
- **Errors:** an address outside both regions, or `be`=0, performs no SRAM or register write. It returns `rdata`=0 with `err`=1.
- Non-DONE cycles: `xbus_rdata`=0, `xbus_err`=0.

## Timing
- Reset (async assert) values:
  - State IDLE; `cnt`, `rdata_q`, `err_q` = 0.
  - `mtime` = 0, `tohost` = 0.
  - All outputs 0; `xbus_stall` = 0 unless `xbus_req`=1.
- Reset asserted mid-ACCESS aborts the access. No SRAM strobe is issued after reset.
- RAM access:
  - Stall is high for WAIT_CYCLES+3 cycles: the IDLE cycle plus WAIT_CYCLES+2 ACCESS cycles.
  - DONE (stall low) is cycle WAIT_CYCLES+3, counted from the request cycle = 0.
- MMIO or error access: stall is high for 1 cycle, DONE is cycle 1.
- Back-to-back requests: the next request is seen in the IDLE cycle after DONE. There is no double execution.
- A TOHOST write takes effect at the IDLE capture edge and is visible on `tohost` from cycle 1.
- An MTIME read returns the value at the capture edge. HI and LO are not atomic with each other.

## Structure
- Shared package `xbus_pkg`:
  - State encoding `XS_IDLE`/`XS_ACCESS`/`XS_DONE`.
  - MMIO offsets `MMIO_MTIME_LO`/`HI`/`TOHOST`.
  - Region-size constants.
- Sub-module `xbus_mmio_regs` holds `mtime`, `tohost`, the byte-enable write logic and the read mux. The FSM, decode and SRAM port stay in the top.

## Test plan
- Load word at 0x0000_0010 with SRAM preloaded 32'hDEADBEEF, WAIT_CYCLES=0:
  - Stall is high for cycles 0–2.
  - `sram_ce` pulses in cycle 1 with `sram_addr`=4.
  - Cycle 3: `xbus_rdata`=32'hDEADBEEF, stall=0.
- Store with `be`=4'b0100, `wdata`=32'h00AB0000, WAIT_CYCLES=3:
  - Single `sram_ce`/`sram_we` pulse with `be`=0100.
  - Stall is high for 6 cycles; DONE in cycle 6 with rdata=0.
- Write TOHOST with `be`=4'b0011, data 32'h12345678, then a word read:
  - `tohost`=32'h00005678 from cycle 1.
  - The read returns 32'h00005678 with a 1-cycle stall.
- Read MTIME_LO 10 cycles after reset release: returns 10 ±0 per the capture-edge rule. MTIME_HI reads 0.
- Access 0x2000_0000 and access with `be`=0: each gives a 1-cycle stall, `xbus_err`=1 in DONE, rdata=0, and no SRAM strobe.
- Assert `rst_n`=0 in ACCESS `cnt`=0 with WAIT_CYCLES=2:
  - Immediately stall=0 and `sram_ce`=0.
  - After release, state is IDLE and a new load completes normally.

Source files
------------

// File: rtl/xbus_pkg.sv
// xbus_pkg: state encoding, MMIO map and byte-merge helper shared by the xbus controller
package xbus_pkg;
  typedef enum logic [1:0] {XS_IDLE, XS_ACCESS, XS_DONE} xs_state_e;
  localparam logic [3:0] MMIO_MTIME_LO = 4'h0;
  localparam logic [3:0] MMIO_MTIME_HI = 4'h4;
  localparam logic [3:0] MMIO_TOHOST = 4'h8;
  localparam int unsigned MMIO_BYTES = 16;
  localparam int unsigned MMIO_SHIFT = 4;
  function automatic int unsigned ram_shift(input int unsigned aw);
    return aw + 2;
  endfunction
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_merge[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/xbus_mem_ctrl_if.sv
// xbus_mem_ctrl_if: core-side xbus request/response bundle
interface xbus_mem_ctrl_if;
  logic req, we, stall, err;
  logic [3:0] be;
  logic [31:0] addr, wdata, rdata;
  modport master (output req, we, be, addr, wdata, input rdata, stall, err);
  modport slave (input req, we, be, addr, wdata, output rdata, stall, err);
endinterface

// File: rtl/xbus_mmio_regs.sv
// xbus_mmio_regs: free-running 64-bit mtime, byte-writable tohost and the MMIO read mux
module xbus_mmio_regs
  import xbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  off,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] tohost
);
  logic [63:0] mtime;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtime <= '0;
      tohost <= '0;
    end else begin
      mtime <= mtime + 64'd1;
      if (wr_en && off == MMIO_TOHOST) tohost <= be_merge(tohost, wdata, be);
    end
  always_comb
    rdata = off == MMIO_MTIME_LO ? mtime[31:0] :
            off == MMIO_MTIME_HI ? mtime[63:32] :
            off == MMIO_TOHOST   ? tohost : '0;
endmodule

// File: rtl/xbus_mem_ctrl.sv
// xbus_mem_ctrl: decodes aligned xbus requests to a single-port SRAM or the MMIO registers
module xbus_mem_ctrl
  import xbus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter int unsigned RAM_AW = 12,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  xbus_mem_ctrl_if.slave    bus,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [RAM_AW-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [31:0]       tohost
);
  localparam logic [4:0] CNT_LAST = 5'(WAIT_CYCLES + 1);
  xs_state_e state, state_n;
  logic [4:0] cnt;
  logic req_we, err_q;
  logic [3:0] req_be;
  logic [RAM_AW-1:0] req_word;
  logic [31:0] req_wdata, rdata_q, mmio_rdata;
  logic ram_hit, mmio_hit, mmio_sel, dec_err, capture;
  assign ram_hit = ((bus.addr - RAM_BASE) >> ram_shift(RAM_AW)) == 32'd0;
  assign mmio_hit = ((bus.addr - MMIO_BASE) >> MMIO_SHIFT) == 32'd0;
  assign dec_err = bus.be == 4'd0 || !(ram_hit || mmio_hit);
  // RAM wins if the two regions are ever parameterised to overlap
  assign mmio_sel = mmio_hit && !ram_hit && !dec_err;
  assign capture = state == XS_IDLE && bus.req;
  xbus_mmio_regs u_mmio (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(capture && bus.we && mmio_sel),
    .off({bus.addr[3:2], 2'b00}),
    .be(bus.be),
    .wdata(bus.wdata),
    .rdata(mmio_rdata),
    .tohost(tohost)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= XS_IDLE;
      cnt <= '0;
      req_we <= 1'b0;
      req_be <= '0;
      req_word <= '0;
      req_wdata <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == XS_ACCESS ? cnt + 5'd1 : '0;
      if (capture) begin
        req_we <= bus.we;
        req_be <= bus.be;
        req_word <= bus.addr[RAM_AW+1:2];
        req_wdata <= bus.wdata;
        err_q <= dec_err;
        rdata_q <= mmio_sel && !bus.we ? mmio_rdata : '0;
      end else if (state == XS_ACCESS && cnt == 5'd1) begin
        rdata_q <= req_we ? '0 : sram_rdata;
      end
    end
  always_comb begin
    state_n = state;
    bus.stall = 1'b0;
    bus.rdata = '0;
    bus.err = 1'b0;
    case (state)
      XS_IDLE: begin
        bus.stall = bus.req;
        if (bus.req) state_n = ram_hit && !dec_err ? XS_ACCESS : XS_DONE;
      end
      XS_ACCESS: begin
        bus.stall = 1'b1;
        if (cnt == CNT_LAST) state_n = XS_DONE;
      end
      XS_DONE: begin
        bus.rdata = rdata_q;
        bus.err = err_q;
        state_n = XS_IDLE;
      end
      default: state_n = XS_IDLE;
    endcase
  end
  assign sram_ce = state == XS_ACCESS && cnt == 5'd0;
  assign sram_we = sram_ce && req_we;
  assign sram_be = sram_ce ? req_be : '0;
  assign sram_addr = sram_ce ? req_word : '0;
  assign sram_wdata = sram_ce ? req_wdata : '0;
endmodule

// File: tb/tb_xbus_mem_ctrl.sv
// tb_xbus_mem_ctrl: directed and randomized checks of xbus_mem_ctrl against a transaction-level model
module tb_xbus_mem_ctrl;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req = 0, we = 0;
  logic [3:0] be = 0;
  logic [31:0] addr = 0, wdata = 0;
  int sel = 0;
  logic [31:0] sram [3][4096];
  logic stall_a [3], err_a [3], ce_a [3], swe_a [3];
  logic [3:0] sbe_a [3];
  logic [11:0] sa_a [3];
  logic [31:0] rdata_a [3], th_a [3];
  logic [63:0] cyc;
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 64'd0 : cyc + 64'd1;

  // three controllers differing only in wait states, one SRAM each
  for (genvar g = 0; g < 3; g++) begin : g_dut
    xbus_mem_ctrl_if bus ();
    logic ce, swe;
    logic [3:0] sbe;
    logic [11:0] sa;
    logic [31:0] swd, srd, th;
    xbus_mem_ctrl #(.WAIT_CYCLES(g == 1 ? 3 : g == 2 ? 2 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .sram_ce(ce), .sram_we(swe), .sram_be(sbe),
      .sram_addr(sa), .sram_wdata(swd), .sram_rdata(srd), .tohost(th));
    assign bus.req = req && sel == g;
    assign bus.we = we;
    assign bus.be = be;
    assign bus.addr = addr;
    assign bus.wdata = wdata;
    assign stall_a[g] = bus.stall;
    assign err_a[g] = bus.err;
    assign rdata_a[g] = bus.rdata;
    assign ce_a[g] = ce;
    assign swe_a[g] = swe;
    assign sbe_a[g] = sbe;
    assign sa_a[g] = sa;
    assign th_a[g] = th;
    always @(posedge clk)
      if (ce) begin
        srd <= sram[g][sa];
        for (int i = 0; i < 4; i++) if (swe && sbe[i]) sram[g][sa][8*i +: 8] = swd[8*i +: 8];
      end
  end

  int vectors = 0, miss = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0] cap_time;
  int ce_cnt;
  logic ce_we;
  logic [3:0] ce_be;
  logic [11:0] ce_addr;
  task automatic txn(input int k, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int n);
    @(negedge clk);
    sel = k; req = 1; we = w; be = b; addr = a; wdata = d;
    cap_time = cyc; n = 0; ce_cnt = 0;
    #1;
    while (stall_a[k] && n < 40) begin
      @(negedge clk);
      n++;
      if (ce_a[k]) begin
        ce_cnt++; ce_we = swe_a[k]; ce_be = sbe_a[k]; ce_addr = sa_a[k];
      end
    end
    rd = rdata_a[k];
    e = err_a[k];
    req = 0;
  endtask

  // reference: region decode, per-word RAM image, tohost copy, mtime = edges since reset release
  logic [31:0] mm [3][64];
  logic [31:0] th_m [3];
  task automatic predict(input int k, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic e, output int n, output int ces);
    bit in_ram, in_mmio;
    in_ram = a < 32'h4000;
    in_mmio = a >= 32'h1000_0000 && a < 32'h1000_0010;
    rd = 0; e = 0; n = 1; ces = 0;
    if (b == 0 || !(in_ram || in_mmio)) e = 1;
    else if (in_ram) begin
      n = (k == 1 ? 3 : k == 2 ? 2 : 0) + 3;
      ces = 1;
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) mm[k][a[7:2]][8*i +: 8] = d[8*i +: 8];
      end else rd = mm[k][a[7:2]];
    end else if (a[3:2] == 2'd2) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) th_m[k][8*i +: 8] = d[8*i +: 8];
      end else rd = th_m[k];
    end else if (!w) rd = a[3:2] == 2'd0 ? cap_time[31:0] : a[3:2] == 2'd1 ? cap_time[63:32] : 32'd0;
  endtask

  task automatic run(input int k, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int n);
    logic [31:0] erd;
    logic ee;
    int en, ces;
    txn(k, w, b, a, d, rd, e, n);
    predict(k, w, b, a, d, erd, ee, en, ces);
    chk($sformatf("rdata k%0d a=%h", k, a), rd, erd);
    chk($sformatf("err k%0d a=%h be=%b", k, a, b), e, ee);
    chk($sformatf("cycles k%0d a=%h", k, a), n, en);
    chk($sformatf("strobes k%0d a=%h", k, a), ce_cnt, ces);
    chk($sformatf("tohost k%0d", k), th_a[k], th_m[k]);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic e;
    int n, r;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4096; i++) sram[k][i] = (i * 32'h9E37_79B1) ^ k;
      for (int i = 0; i < 64; i++) mm[k][i] = (i * 32'h9E37_79B1) ^ k;
      th_m[k] = 0;
    end
    sram[0][4] = 32'hDEAD_BEEF;
    mm[0][4] = 32'hDEAD_BEEF;
    #2;
    chk("reset stall", stall_a[0], 1'b0);
    chk("reset rdata", rdata_a[0], 32'd0);
    chk("reset err", err_a[0], 1'b0);
    chk("reset sram_ce", ce_a[0], 1'b0);
    chk("reset tohost", th_a[0], 32'd0);
    @(negedge clk) rst_n = 1;
    repeat (9) @(negedge clk);
    run(0, 0, 4'hF, 32'h1000_0000, 0, rd, e, n);
    chk("mtime_lo at 10", rd, 32'd10);
    run(0, 0, 4'hF, 32'h1000_0004, 0, rd, e, n);
    chk("mtime_hi", rd, 32'd0);
    run(0, 0, 4'hF, 32'h0000_0010, 0, rd, e, n);
    chk("load data", rd, 32'hDEAD_BEEF);
    chk("load cycles", n, 3);
    chk("load sram_addr", ce_addr, 12'd4);
    chk("load sram_we", ce_we, 1'b0);
    run(1, 1, 4'b0100, 32'h0000_0020, 32'h00AB_0000, rd, e, n);
    chk("store cycles", n, 6);
    chk("store rdata", rd, 32'd0);
    chk("store strobes", ce_cnt, 1);
    chk("store sram_we", ce_we, 1'b1);
    chk("store sram_be", ce_be, 4'b0100);
    chk("store sram word", sram[1][8], mm[1][8]);
    run(0, 1, 4'b0011, 32'h1000_0008, 32'h1234_5678, rd, e, n);
    chk("tohost after write", th_a[0], 32'h0000_5678);
    run(0, 0, 4'hF, 32'h1000_0008, 0, rd, e, n);
    chk("tohost readback", rd, 32'h0000_5678);
    chk("tohost read cycles", n, 1);
    run(0, 0, 4'hF, 32'h2000_0000, 0, rd, e, n);
    chk("unmapped err", e, 1'b1);
    run(0, 1, 4'b0000, 32'h0000_0010, 32'h0BAD_F00D, rd, e, n);
    chk("be0 err", e, 1'b1);
    chk("be0 no write", sram[0][4], 32'hDEAD_BEEF);
    run(0, 1, 4'hF, 32'h1000_000C, 32'hFFFF_FFFF, rd, e, n);
    chk("reserved no err", e, 1'b0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      a = r < 6 ? {24'd0, 6'($urandom_range(0, 63)), 2'b00} :
          r < 9 ? 32'h1000_0000 + 32'($urandom_range(0, 3)) * 4 :
          ($urandom_range(0, 1) != 0 ? 32'h0000_4000 : 32'h1000_0010);
      run($urandom_range(0, 1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, rd, e, n);
    end
    @(negedge clk);
    sel = 2; req = 1; we = 0; be = 4'hF; addr = 32'h0000_0030;
    @(negedge clk);
    chk("access strobe before reset", ce_a[2], 1'b1);
    rst_n = 0;
    req = 0;
    #1;
    chk("reset mid-access stall", stall_a[2], 1'b0);
    chk("reset mid-access sram_ce", ce_a[2], 1'b0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 3; k++) th_m[k] = 0;
    chk("tohost cleared", th_a[0], 32'd0);
    run(2, 0, 4'hF, 32'h0000_0030, 0, rd, e, n);
    chk("post-reset load cycles", n, 5);
    run(2, 0, 4'hF, 32'h1000_0000, 0, rd, e, n);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
